// File: rtl/spi_flash_arbiter.sv
// -----------------------------------------------------------------------------
// spi_flash_arbiter
//
// Shares one SPI flash between two SPI masters: requester 0 (USB bootloader)
// and requester 1 (auxiliary flash reader). A requester raises rqN_req, waits
// for rqN_gnt, and then drives the flash directly through a zero-latency mux.
// Ties in IDLE are broken round-robin. After every grant the flash CS is held
// high for TURNAROUND_CYCLES cycles. A grant held for TIMEOUT_CYCLES cycles is
// forcibly revoked, and timeout_err pulses for one cycle.
//
// Parameters
//   TURNAROUND_CYCLES  CS-high gap between grants, 1..255
//   TIMEOUT_CYCLES     maximum grant length in cycles, 2..65535
//
// Ports
//   clk_48mhz           clock
//   reset               synchronous, active-high reset
//   rqN_req             bus request from requester N
//   rqN_gnt             bus granted to requester N (registered)
//   rqN_cs/mosi/sck     SPI master outputs of requester N
//   rqN_miso            flash MISO routed to requester N (0 when not granted)
//   spi_cs/mosi/sck     shared flash pins (idle: cs=1, sck=0, mosi=0)
//   spi_miso            shared flash MISO
//   busy                high whenever the arbiter is not IDLE
//   timeout_err         one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module spi_flash_arbiter #(
    parameter int unsigned TURNAROUND_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES    = 65535
) (
    input  logic clk_48mhz,
    input  logic reset,
    input  logic rq0_req,
    input  logic rq1_req,
    output logic rq0_gnt,
    output logic rq1_gnt,
    input  logic rq0_cs,
    input  logic rq0_mosi,
    input  logic rq0_sck,
    input  logic rq1_cs,
    input  logic rq1_mosi,
    input  logic rq1_sck,
    output logic rq0_miso,
    output logic rq1_miso,
    output logic spi_cs,
    output logic spi_mosi,
    output logic spi_sck,
    input  logic spi_miso,
    output logic busy,
    output logic timeout_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        GAP    = 2'd3
    } state_e;

    // Terminal counts: the counters clear on state entry, so the last cycle
    // of a state is the one where the counter equals the length minus one.
    localparam logic [15:0] GRANT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  GAP_LAST   = 8'(TURNAROUND_CYCLES - 1);

    state_e      state_q;
    logic        last_q;        // requester served most recently
    logic [15:0] grant_cnt_q;
    logic [7:0]  gap_cnt_q;
    logic        gnt0_q;
    logic        gnt1_q;
    logic        busy_q;
    logic        timeout_err_q;

    logic [15:0] grant_cnt_d;
    logic [7:0]  gap_cnt_d;
    logic        pick_valid;
    logic        pick1;
    logic        release_hit;
    logic        timeout_hit;

    assign grant_cnt_d = grant_cnt_q + 16'd1;
    assign gap_cnt_d   = gap_cnt_q + 8'd1;

    // Round-robin: on a tie requester 1 wins only if requester 0 was last.
    assign pick_valid  = rq0_req | rq1_req;
    assign pick1       = rq1_req & (~rq0_req | ~last_q);

    // A dropped request only releases the bus once the owner has raised CS,
    // so a transfer in flight is never cut short by the request line.
    assign release_hit = gnt1_q ? (~rq1_req & rq1_cs) : (~rq0_req & rq0_cs);
    assign timeout_hit = (grant_cnt_q == GRANT_LAST);

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state_q       <= IDLE;
            last_q        <= 1'b1;
            grant_cnt_q   <= '0;
            gap_cnt_q     <= '0;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_q     <= pick1 ? GRANT1 : GRANT0;
                        last_q      <= pick1;
                        grant_cnt_q <= '0;
                        gnt0_q      <= ~pick1;
                        gnt1_q      <= pick1;
                        busy_q      <= 1'b1;
                    end
                end
                GRANT0, GRANT1: begin
                    grant_cnt_q <= grant_cnt_d;
                    // Timeout takes precedence over a coincident release.
                    if (timeout_hit || release_hit) begin
                        state_q       <= GAP;
                        gap_cnt_q     <= '0;
                        gnt0_q        <= 1'b0;
                        gnt1_q        <= 1'b0;
                        timeout_err_q <= timeout_hit;
                    end
                end
                GAP: begin
                    gap_cnt_q <= gap_cnt_d;
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rq0_gnt     = gnt0_q;
    assign rq1_gnt     = gnt1_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

    // Zero-cycle pass-through for the owner; parked pins otherwise.
    assign spi_cs   = gnt0_q ? rq0_cs   : (gnt1_q ? rq1_cs   : 1'b1);
    assign spi_mosi = gnt0_q ? rq0_mosi : (gnt1_q ? rq1_mosi : 1'b0);
    assign spi_sck  = gnt0_q ? rq0_sck  : (gnt1_q ? rq1_sck  : 1'b0);
    assign rq0_miso = gnt0_q & spi_miso;
    assign rq1_miso = gnt1_q & spi_miso;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Bench for spi_flash_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model
// that tracks owner / grant age / remaining gap cycles.
module tb_spi_flash_arbiter;

    localparam int TURN = 4;
    localparam int TMO  = 16;

    logic clk_48mhz = 1'b0;
    logic reset     = 1'b1;
    logic rq0_req = 1'b0, rq1_req = 1'b0;
    logic rq0_cs = 1'b1, rq0_mosi = 1'b0, rq0_sck = 1'b0;
    logic rq1_cs = 1'b1, rq1_mosi = 1'b0, rq1_sck = 1'b0;
    logic spi_miso = 1'b0;
    logic rq0_gnt, rq1_gnt, rq0_miso, rq1_miso;
    logic spi_cs, spi_mosi, spi_sck, busy, timeout_err;

    spi_flash_arbiter #(.TURNAROUND_CYCLES(TURN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_48mhz(clk_48mhz), .reset(reset),
        .rq0_req(rq0_req), .rq1_req(rq1_req),
        .rq0_gnt(rq0_gnt), .rq1_gnt(rq1_gnt),
        .rq0_cs(rq0_cs), .rq0_mosi(rq0_mosi), .rq0_sck(rq0_sck),
        .rq1_cs(rq1_cs), .rq1_mosi(rq1_mosi), .rq1_sck(rq1_sck),
        .rq0_miso(rq0_miso), .rq1_miso(rq1_miso),
        .spi_cs(spi_cs), .spi_mosi(spi_mosi), .spi_sck(spi_sck),
        .spi_miso(spi_miso), .busy(busy), .timeout_err(timeout_err)
    );

    always #10 clk_48mhz = ~clk_48mhz;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int owner    = -1;   // -1: nobody owns the flash
    int age      = 0;    // grant cycles completed by the owner
    int gap_left = 0;    // CS-high cycles still to run
    int last_srv = 1;
    int m_pick;
    bit m_terr   = 1'b0;
    bit m_valid  = 1'b0;

    initial begin
        forever begin
            @(posedge clk_48mhz);
            if (reset) begin
                owner = -1; age = 0; gap_left = 0; last_srv = 1; m_terr = 1'b0;
                m_valid = 1'b1;
            end else if (m_valid) begin
                m_terr = 1'b0;
                if (owner >= 0) begin
                    age++;
                    if (age >= TMO) begin
                        owner = -1; gap_left = TURN; m_terr = 1'b1;
                    end else if ((owner == 0) ? (!rq0_req && rq0_cs) : (!rq1_req && rq1_cs)) begin
                        owner = -1; gap_left = TURN;
                    end
                end else if (gap_left > 0) begin
                    gap_left--;
                end else begin
                    m_pick = -1;
                    if (rq0_req && rq1_req) m_pick = 1 - last_srv;
                    else if (rq0_req)       m_pick = 0;
                    else if (rq1_req)       m_pick = 1;
                    if (m_pick >= 0) begin
                        owner = m_pick; last_srv = m_pick; age = 0;
                    end
                end
            end
        end
    end

    // Compare every cycle, mid-cycle, against the model.
    initial begin
        forever begin
            @(negedge clk_48mhz);
            if (m_valid) begin
                chk("cmp_gnt0", rq0_gnt, owner == 0);
                chk("cmp_gnt1", rq1_gnt, owner == 1);
                chk("cmp_busy", busy, (owner >= 0) || (gap_left > 0));
                chk("cmp_terr", timeout_err, m_terr);
                chk("cmp_cs",   spi_cs,   owner == 0 ? rq0_cs   : owner == 1 ? rq1_cs   : 1'b1);
                chk("cmp_mosi", spi_mosi, owner == 0 ? rq0_mosi : owner == 1 ? rq1_mosi : 1'b0);
                chk("cmp_sck",  spi_sck,  owner == 0 ? rq0_sck  : owner == 1 ? rq1_sck  : 1'b0);
                chk("cmp_miso0", rq0_miso, owner == 0 ? spi_miso : 1'b0);
                chk("cmp_miso1", rq1_miso, owner == 1 ? spi_miso : 1'b0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk_48mhz);
        #1;
    endtask

    task automatic idle_pins();
        rq0_cs = 1'b1; rq0_mosi = 1'b0; rq0_sck = 1'b0;
        rq1_cs = 1'b1; rq1_mosi = 1'b0; rq1_sck = 1'b0;
    endtask

    initial begin
        // Reset with requester pins driven active so parked outputs are visible.
        reset = 1'b1;
        rq0_cs = 1'b0; rq0_mosi = 1'b1; rq0_sck = 1'b1;
        rq1_cs = 1'b0; rq1_mosi = 1'b1; rq1_sck = 1'b1;
        spi_miso = 1'b1;
        repeat (3) tick();
        #1;
        chk("rst_gnt0", rq0_gnt, 1'b0);
        chk("rst_gnt1", rq1_gnt, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_terr", timeout_err, 1'b0);
        chk("rst_cs", spi_cs, 1'b1);
        chk("rst_sck", spi_sck, 1'b0);
        chk("rst_mosi", spi_mosi, 1'b0);
        chk("rst_miso0", rq0_miso, 1'b0);
        chk("rst_miso1", rq1_miso, 1'b0);

        // Single requester 0: grant one cycle after the sampled request.
        reset = 1'b0; idle_pins(); spi_miso = 1'b0;
        repeat (9) tick();
        rq0_req = 1'b1;
        tick(); #1;
        chk("s1_gnt0", rq0_gnt, 1'b1);
        chk("s1_gnt1", rq1_gnt, 1'b0);
        chk("s1_busy", busy, 1'b1);
        rq0_cs = 1'b0; rq0_mosi = 1'b1; rq0_sck = 1'b1; spi_miso = 1'b1; #1;
        chk("s1_cs_pass", spi_cs, 1'b0);
        chk("s1_mosi_pass", spi_mosi, 1'b1);
        chk("s1_sck_pass", spi_sck, 1'b1);
        chk("s1_miso0_pass", rq0_miso, 1'b1);
        chk("s1_miso1_zero", rq1_miso, 1'b0);
        rq0_mosi = 1'b0; spi_miso = 1'b0; #1;
        chk("s1_mosi_pass0", spi_mosi, 1'b0);
        chk("s1_miso0_pass0", rq0_miso, 1'b0);
        repeat (3) tick();
        rq0_req = 1'b0; rq0_cs = 1'b1; rq0_sck = 1'b0;
        tick(); #1;
        chk("s1_rel_gnt0", rq0_gnt, 1'b0);
        chk("s1_rel_busy", busy, 1'b1);
        chk("s1_rel_cs", spi_cs, 1'b1);
        for (int i = 0; i < TURN - 1; i++) begin
            tick(); #1;
            chk("s1_gap_busy", busy, 1'b1);
        end
        tick(); #1;
        chk("s1_idle_busy", busy, 1'b0);
        chk("s1_idle_cs", spi_cs, 1'b1);

        // Round-robin ties.
        reset = 1'b1; tick(); reset = 1'b0; idle_pins();
        rq0_req = 1'b1; rq1_req = 1'b1;
        tick(); #1;
        chk("s2_tie1_gnt0", rq0_gnt, 1'b1);
        chk("s2_tie1_gnt1", rq1_gnt, 1'b0);
        rq0_cs = 1'b0; repeat (2) tick();
        rq0_req = 1'b0; rq0_cs = 1'b1;
        tick(); #1;
        chk("s2_rel0_gnt0", rq0_gnt, 1'b0);
        for (int i = 0; i < TURN - 1; i++) begin
            tick(); #1;
            chk("s2_gap_gnt1", rq1_gnt, 1'b0);
        end
        tick(); #1;
        chk("s2_idle_busy", busy, 1'b0);
        tick(); #1;
        chk("s2_gnt1", rq1_gnt, 1'b1);
        rq1_cs = 1'b0; rq0_req = 1'b1;
        repeat (2) tick(); #1;
        chk("s2_no_preempt_gnt0", rq0_gnt, 1'b0);
        chk("s2_no_preempt_gnt1", rq1_gnt, 1'b1);
        rq1_req = 1'b0; rq1_cs = 1'b1;
        tick(); #1;
        chk("s2_rel1_gnt1", rq1_gnt, 1'b0);
        rq1_req = 1'b1;
        repeat (TURN) tick(); #1;
        chk("s2_idle2_busy", busy, 1'b0);
        tick(); #1;
        chk("s2_tie2_gnt0", rq0_gnt, 1'b1);
        chk("s2_tie2_gnt1", rq1_gnt, 1'b0);

        // Request dropped mid-byte: grant held until CS rises.
        rq0_cs = 1'b0; tick();
        rq0_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("s3_hold_gnt0", rq0_gnt, 1'b1);
        end
        rq0_cs = 1'b1;
        tick(); #1;
        chk("s3_rel_gnt0", rq0_gnt, 1'b0);
        chk("s3_rel_busy", busy, 1'b1);

        // Timeout: requester 1 (still requesting) holds CS low.
        rq1_cs = 1'b0;
        repeat (TURN) tick();
        tick(); #1;
        chk("s4_gnt1", rq1_gnt, 1'b1);
        for (int i = 1; i < TMO; i++) begin
            tick(); #1;
            chk("s4_held_gnt1", rq1_gnt, 1'b1);
            chk("s4_held_terr", timeout_err, 1'b0);
        end
        tick(); #1;
        chk("s4_to_gnt1", rq1_gnt, 1'b0);
        chk("s4_to_terr", timeout_err, 1'b1);
        chk("s4_to_cs", spi_cs, 1'b1);
        chk("s4_to_busy", busy, 1'b1);
        tick(); #1;
        chk("s4_terr_once", timeout_err, 1'b0);

        // Reset while in GRANT1.
        repeat (TURN - 1) tick();
        tick(); #1;
        chk("s5_pre_gnt1", rq1_gnt, 1'b1);
        reset = 1'b1;
        tick(); #1;
        chk("s5_rst_gnt0", rq0_gnt, 1'b0);
        chk("s5_rst_gnt1", rq1_gnt, 1'b0);
        chk("s5_rst_cs", spi_cs, 1'b1);
        chk("s5_rst_busy", busy, 1'b0);
        chk("s5_rst_terr", timeout_err, 1'b0);
        reset = 1'b0; rq0_req = 1'b1; rq1_req = 1'b1; rq1_cs = 1'b1;
        tick(); #1;
        chk("s5_tie_gnt0", rq0_gnt, 1'b1);

        // Request pulse confined to GAP produces no grant.
        rq0_req = 1'b0; rq1_req = 1'b0; rq0_cs = 1'b1; spi_miso = 1'b1;
        tick();
        rq1_req = 1'b1;
        tick();
        rq1_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(); #1;
            chk("s6_gnt1", rq1_gnt, 1'b0);
            chk("s6_miso1", rq1_miso, 1'b0);
        end

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) rq0_req = ~rq0_req;
            if ($urandom_range(0, 7) == 0) rq1_req = ~rq1_req;
            if ($urandom_range(0, 3) == 0) rq0_cs = ~rq0_cs;
            if ($urandom_range(0, 3) == 0) rq1_cs = ~rq1_cs;
            rq0_mosi = 1'($urandom); rq0_sck = 1'($urandom);
            rq1_mosi = 1'($urandom); rq1_sck = 1'($urandom);
            spi_miso = 1'($urandom);
            tick();
        end
        reset = 1'b0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_flash_arbiter.md
SPI_FLASH_ARBITER -- requirements
Module: spi_flash_arbiter

Interface
REQ-001 SHALL provide parameter TURNAROUND_CYCLES, default 4: number of cycles the flash CS is held high between grants (legal range 1..255).
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 65535: maximum number of cycles a grant may be held (legal range 2..65535, 16-bit counter).
REQ-003 SHALL have port: clk_48mhz  in  1  clock; reset is synchronous, active-high.
REQ-004 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: rq0_req / rq1_req  in  1  bus request from requester 0 (USB bootloader) / requester 1 (auxiliary flash reader).
REQ-006 SHALL have ports: rq0_gnt / rq1_gnt  out  1  bus granted to requester 0 / 1.
REQ-007 SHALL have ports: rqN_cs, rqN_mosi, rqN_sck  in  1 each  SPI master outputs of requester N.
REQ-008 SHALL have ports: rqN_miso  out  1  flash MISO routed to requester N.
REQ-009 SHALL have ports: spi_cs, spi_mosi, spi_sck  out  1 each, and spi_miso  in  1: the shared flash pins.
REQ-010 SHALL have port: busy  out  1  high in any state other than IDLE.
REQ-011 SHALL have port: timeout_err  out  1  one-cycle pulse on forced release.

Function
REQ-012 SHALL implement the FSM states IDLE, GRANT0, GRANT1 and GAP.
REQ-013 IDLE: if exactly one rqN_req is high at edge N, the FSM SHALL enter GRANTN and assert rqN_gnt from cycle N+1 (registered, 1-cycle latency).
REQ-014 If both requests are high in IDLE, the FSM SHALL grant the requester that was not served last (round-robin); after reset, requester 0 wins the first tie.
REQ-015 In GRANTN, spi_cs/spi_mosi/spi_sck SHALL equal rqN_cs/rqN_mosi/rqN_sck combinationally (zero-cycle pass-through), and rqN_miso SHALL equal spi_miso.
REQ-016 In GRANTN, the non-granted requester's miso SHALL be 0 and its gnt SHALL be 0.
REQ-017 In any state other than GRANT0/GRANT1, the flash outputs SHALL be spi_cs=1, spi_sck=0, spi_mosi=0, and both rqN_miso SHALL be 0.
REQ-018 Release: GRANTN SHALL go to GAP on the first edge where rqN_req=0 and rqN_cs=1; a req drop while rqN_cs=0 SHALL NOT release the grant, which is held until CS rises.
REQ-019 The grant counter SHALL clear on entry to GRANTN and increment each cycle in GRANTN.
REQ-020 When the grant counter reaches TIMEOUT_CYCLES-1, the FSM SHALL go to GAP regardless of req/cs and pulse timeout_err for exactly the first GAP cycle.
REQ-021 GAP SHALL last exactly TURNAROUND_CYCLES cycles with the gap counter cleared on entry, then go to IDLE; requests arriving during GAP SHALL be held pending and evaluated in IDLE.
REQ-022 The last-served pointer SHALL update on entry to GRANTN to N.
REQ-023 Simultaneous events: a timeout and a normal release on the same edge SHALL count as a timeout (timeout_err pulses).
REQ-024 A requester deasserting rqN_req before it is granted SHALL cause no grant; gnt is never asserted without a req sampled high.

Reset
REQ-025 On reset, the FSM SHALL enter IDLE and SHALL drive rq0_gnt=rq1_gnt=0, busy=0, timeout_err=0, spi_cs=1, spi_sck=0, spi_mosi=0, rqN_miso=0, and the last-served pointer SHALL select requester 1 so that requester 0 wins the first tie.
REQ-026 Reset asserted mid-transaction SHALL take effect at the next clk_48mhz edge, abandoning the grant with no GAP and no timeout_err.

Verification
REQ-027 The bench SHALL cover: single requester 0 req at cycle 10 -> rq0_gnt=1 at cycle 11, busy=1, spi pins track rq0 pins same cycle; req drop with cs=1 -> GAP for 4 cycles, then IDLE, spi_cs=1.
REQ-028 The bench SHALL cover: both requests high simultaneously after reset -> rq0 granted; after its release and GAP, with rq1 still high -> rq1 granted; on a second tie -> rq0 granted.
REQ-029 The bench SHALL cover: rq0 drops req while rq0_cs=0 during a byte transfer -> rq0_gnt stays 1 until rq0_cs=1, then GAP on that edge.
REQ-030 The bench SHALL cover: TIMEOUT_CYCLES=16 with rq1 holding cs low -> GAP entered after 16 grant cycles, spi_cs=1, timeout_err high for exactly 1 cycle, rq1_gnt=0.
REQ-031 The bench SHALL cover: reset pulsed while in GRANT1 -> next edge: all gnt=0, spi_cs=1, busy=0, timeout_err=0; then a tie -> rq0 granted.
REQ-032 The bench SHALL cover: rq1_req pulsed high during GAP only -> no grant after GAP; rq1 rxd miso is 0 throughout.
